// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: receives a length-prefixed, checksummed frame of little-endian
// 32-bit words and writes them into the instruction memory while holding the core in reset.
module instr_mem_loader #(
    parameter int          MEMORY_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    // Byte handshake: a byte moves only on a cycle where rx_valid && rx_ready are both 1;
    // rx_valid while rx_ready is 0 is ignored and the byte is lost.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] asm_q, asm_d;
    logic [7:0]  csum_q, csum_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        byte_acc;
    logic [15:0] len_full;
    logic [15:0] idx_next;

    assign rx_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
    assign byte_acc = rx_valid && rx_ready;
    assign len_full = {rx_data, len_q[7:0]};
    assign idx_next = idx_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        asm_d       = asm_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hold_d      = hold_q;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    len_d   = 16'd0;
                    idx_d   = 16'd0;
                    lane_d  = 2'd0;
                    asm_d   = 24'd0;
                    csum_d  = 8'd0;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_LEN_LO: begin
                if (byte_acc) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (byte_acc) begin
                    len_d = len_full;
                    if ({16'd0, len_full} > 32'(MEMORY_DEPTH)) begin
                        state_d = S_ERROR;
                        hold_d  = 1'b0;
                        err_d   = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (byte_acc) begin
                    csum_d = csum_q + rx_data;
                    case (lane_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: asm_d     = asm_q;
                    endcase
                    lane_d = lane_q + 2'd1;
                    // The 4th byte completes the word; it is copied out so assembly of the
                    // next word can proceed while the write strobe is high.
                    if (lane_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {rx_data, asm_q};
                        mem_addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                        idx_d       = idx_next;
                        if (idx_next == len_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (byte_acc) begin
                    hold_d = 1'b0;
                    if (rx_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                hold_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            len_q       <= 16'd0;
            idx_q       <= 16'd0;
            lane_q      <= 2'd0;
            asm_q       <= 24'd0;
            csum_q      <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'd0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            asm_q       <= asm_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = hold_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule
